// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl
//   Decode-stage scoreboard and hazard controller for the 5-stage core.
//   Tracks the destinations of in-flight instructions in a shadow EXE/MEM/WB
//   pipeline. It drives the load-use stall, the per-operand forwarding selects
//   and the IF flush pulse for a taken branch.
// Ports
//   clk, reset            clock; synchronous active-high reset
//   id_valid              ID holds a valid instruction
//   id_rf_raddr1/2        ID source registers (r0 never hazards)
//   id_rf_we/waddr        ID destination write enable / register
//   id_res_from_mem       ID instruction is a load
//   id_br_taken           ID resolves a taken branch/jump
//   exe_allowin           EXE accepts a new instruction this cycle
//   Load_DataHazard       stall ID: a load in EXE feeds an ID source
//   fwd1_sel/fwd2_sel     0 regfile, 1 EXE, 2 MEM, 3 WB
//   if_flush              discard the IF instruction after a taken branch
//   stall_cnt             saturating count of load-use stall cycles
module id_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [4:0]             id_rf_raddr1,
  input  logic [4:0]             id_rf_raddr2,
  input  logic                   id_rf_we,
  input  logic [4:0]             id_rf_waddr,
  input  logic                   id_res_from_mem,
  input  logic                   id_br_taken,
  input  logic                   exe_allowin,
  output logic                   Load_DataHazard,
  output logic [1:0]             fwd1_sel,
  output logic [1:0]             fwd2_sel,
  output logic                   if_flush,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] waddr;
    logic       ld;
  } slot_t;

  slot_t exe_s, mem_s, wb_s;
  logic  id_fire;

  function automatic logic writes(input slot_t s, input logic [4:0] r);
    return s.v & s.we & (s.waddr == r) & (r != 5'd0);
  endfunction

  // Youngest producer wins. A load in EXE has no data yet: ID stalls on it,
  // so the search falls through to the older slots.
  function automatic logic [1:0] pick(input logic vld, input logic [4:0] r,
                                      input slot_t e, input slot_t m,
                                      input slot_t w);
    if (!vld || r == 5'd0)       return 2'd0;
    if (writes(e, r) && !e.ld)   return 2'd1;
    if (writes(m, r))            return 2'd2;
    if (writes(w, r))            return 2'd3;
    return 2'd0;
  endfunction

  always_comb begin
    Load_DataHazard = id_valid & exe_s.ld &
                      (writes(exe_s, id_rf_raddr1) | writes(exe_s, id_rf_raddr2));
    id_fire  = id_valid & ~Load_DataHazard & exe_allowin;
    // A stalled branch is re-evaluated next cycle, so only a firing one flushes.
    if_flush = id_br_taken & id_fire;
    fwd1_sel = pick(id_valid, id_rf_raddr1, exe_s, mem_s, wb_s);
    fwd2_sel = pick(id_valid, id_rf_raddr2, exe_s, mem_s, wb_s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exe_s     <= '0;
      mem_s     <= '0;
      wb_s      <= '0;
      stall_cnt <= '0;
    end else begin
      // Slots only move when EXE accepts; a stall into ID inserts a bubble.
      if (exe_allowin) begin
        exe_s <= id_fire ? slot_t'{1'b1, id_rf_we, id_rf_waddr, id_res_from_mem}
                         : slot_t'('0);
        mem_s <= exe_s;
        wb_s  <= mem_s;
      end
      if (Load_DataHazard && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rf_raddr1 = '0, id_rf_raddr2 = '0, id_rf_waddr = '0;
  logic       id_rf_we = 1'b0, id_res_from_mem = 1'b0, id_br_taken = 1'b0;
  logic       exe_allowin = 1'b1;

  logic        hz, fl, hz16, fl16;
  logic [1:0]  f1, f2, f1_16, f2_16;
  logic [1:0]  cnt2;
  logic [15:0] cnt16;

  always #5 clk = ~clk;

  // Narrow counter instance exercises saturation; default-width one checks the count.
  id_hazard_ctrl #(.STALL_CNT_W(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rf_raddr1(id_rf_raddr1), .id_rf_raddr2(id_rf_raddr2),
    .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr),
    .id_res_from_mem(id_res_from_mem), .id_br_taken(id_br_taken),
    .exe_allowin(exe_allowin), .Load_DataHazard(hz),
    .fwd1_sel(f1), .fwd2_sel(f2), .if_flush(fl), .stall_cnt(cnt2)
  );

  id_hazard_ctrl dut16 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rf_raddr1(id_rf_raddr1), .id_rf_raddr2(id_rf_raddr2),
    .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr),
    .id_res_from_mem(id_res_from_mem), .id_br_taken(id_br_taken),
    .exe_allowin(exe_allowin), .Load_DataHazard(hz16),
    .fwd1_sel(f1_16), .fwd2_sel(f2_16), .if_flush(fl16), .stall_cnt(cnt16)
  );

  typedef struct {
    string nm;
    int    hz, f1, f2, fl, cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0d expected=%0d", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, once per queued expectation.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.nm, "hazard",   int'(hz),    e.hz);
      cmp(e.nm, "fwd1",     int'(f1),    e.f1);
      cmp(e.nm, "fwd2",     int'(f2),    e.f2);
      cmp(e.nm, "flush",    int'(fl),    e.fl);
      cmp(e.nm, "cnt_sat2", int'(cnt2),  (e.cnt > 3) ? 3 : e.cnt);
      cmp(e.nm, "cnt16",    int'(cnt16), e.cnt);
      cmp(e.nm, "hazard16", int'(hz16),  e.hz);
    end
  end

  // One ID cycle: drive inputs just after the edge, queue the expected outputs.
  task automatic step(input string nm, input int rst, input int v, input int r1,
                      input int r2, input int we, input int wa, input int ld,
                      input int br, input int al, input int chk, input int ehz,
                      input int ef1, input int ef2, input int efl, input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst[0];
    id_valid        = v[0];
    id_rf_raddr1    = 5'(r1);
    id_rf_raddr2    = 5'(r2);
    id_rf_we        = we[0];
    id_rf_waddr     = 5'(wa);
    id_res_from_mem = ld[0];
    id_br_taken     = br[0];
    exe_allowin     = al[0];
    if (chk != 0) begin
      e.nm = nm; e.hz = ehz; e.f1 = ef1; e.f2 = ef2; e.fl = efl; e.cnt = ec;
      q.push_back(e);
    end
  endtask

  initial begin
    //          name          rst v  r1 r2 we wa ld br al chk hz f1 f2 fl cnt
    step("rst0",         1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    step("rst1",         1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0);
    step("ld_r5",        0, 1, 0, 0, 1, 5, 1, 0, 1, 1,  0, 0, 0, 0, 0);
    step("use_r5",       0, 1, 5, 7, 1, 6, 0, 0, 1, 1,  1, 0, 0, 0, 0);
    step("use_r5_rel",   0, 1, 5, 7, 1, 6, 0, 0, 1, 1,  0, 2, 0, 0, 1);
    step("add_r4",       0, 1, 0, 0, 1, 4, 0, 0, 1, 1,  0, 0, 0, 0, 1);
    step("rd_r4_exe",    0, 1, 4, 6, 0, 0, 0, 0, 1, 1,  0, 1, 2, 0, 1);
    step("rd_r4_mem",    0, 1, 4, 6, 0, 0, 0, 0, 1, 1,  0, 2, 3, 0, 1);
    step("rd_r4_wb",     0, 1, 4, 5, 0, 0, 0, 0, 1, 1,  0, 3, 0, 0, 1);
    step("ld_r0",        0, 1, 0, 0, 1, 0, 1, 0, 1, 1,  0, 0, 0, 0, 1);
    step("rd_r0",        0, 1, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1);
    step("add_r8a",      0, 1, 0, 0, 1, 8, 0, 0, 1, 1,  0, 0, 0, 0, 1);
    step("add_r8b",      0, 1, 0, 0, 1, 8, 0, 0, 1, 1,  0, 0, 0, 0, 1);
    step("invalid_rd",   0, 0, 8, 8, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1);
    step("mem_wb_same",  0, 1, 8, 8, 0, 0, 0, 0, 1, 1,  0, 2, 2, 0, 1);
    step("br_fire",      0, 1, 0, 0, 0, 0, 0, 1, 1, 1,  0, 0, 0, 1, 1);
    step("idle",         0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1);
    step("ld_r9",        0, 1, 0, 0, 1, 9, 1, 0, 1, 1,  0, 0, 0, 0, 1);
    step("br_stall",     0, 1, 9, 0, 0, 0, 0, 1, 1, 1,  1, 0, 0, 0, 1);
    step("br_release",   0, 1, 9, 0, 0, 0, 0, 1, 1, 1,  0, 2, 0, 1, 2);
    step("ld_r10",       0, 1, 0, 0, 1, 10, 1, 0, 1, 1, 0, 0, 0, 0, 2);
    step("hold1",        0, 1, 0, 10, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2);
    step("hold2_br",     0, 1, 0, 10, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 3);
    step("hold3",        0, 1, 0, 10, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4);
    step("hold_rel",     0, 1, 0, 10, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 5);
    step("r10_from_mem", 0, 1, 0, 10, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 6);
    step("noallow_br",   0, 1, 0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 6);
    step("ld_r11",       0, 1, 0, 0, 1, 11, 1, 0, 1, 1, 0, 0, 0, 0, 6);
    step("rst_mid",      1, 1, 11, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 6);
    step("post_rst",     0, 1, 11, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    step("drain",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
